// File: rtl/shift_issue_stage_pkg.sv
// Shared constants for the shift issue stage: shifter op codes, the shift
// opcode, funct values and instruction field positions.
package shift_issue_stage_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b011;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;

  localparam logic [5:0] SHIFT_OPCODE = 6'b000001;

  localparam logic [3:0] FN_SHLL  = 4'd0;
  localparam logic [3:0] FN_SHRL  = 4'd1;
  localparam logic [3:0] FN_SHRA  = 4'd2;
  localparam logic [3:0] FN_SHLLV = 4'd4;
  localparam logic [3:0] FN_SHRLV = 4'd5;
  localparam logic [3:0] FN_SHRAV = 4'd6;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int SHAMT_MSB = 15;
  localparam int SHAMT_LSB = 11;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
    logic       use_rt;  // amount comes from rt value instead of shamt
  } funct_dec_t;

  function automatic funct_dec_t decode_funct(input logic [3:0] funct);
    funct_dec_t d;
    d = '{legal: 1'b1, op: OP_NONE, use_rt: 1'b0};
    case (funct)
      FN_SHLL:  d.op = OP_SLL;
      FN_SHRL:  d.op = OP_SRL;
      FN_SHRA:  d.op = OP_SRA;
      FN_SHLLV: begin d.op = OP_SLL; d.use_rt = 1'b1; end
      FN_SHRLV: begin d.op = OP_SRL; d.use_rt = 1'b1; end
      FN_SHRAV: begin d.op = OP_SRA; d.use_rt = 1'b1; end
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Bus bundle of the shift issue stage: instruction input, register-file read
// ports, writeback bypass inputs and the issued-entry output.
interface shift_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Handshakes: a beat transfers on a rising edge where valid && ready are both
  // high; the sender holds its payload stable while valid && !ready.
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              flush;

  logic [REG_AW-1:0] rf_raddr_a;
  logic [REG_AW-1:0] rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;

  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_op;
  logic [DATA_W-1:0] out_a;
  logic [4:0]        out_sh_amt;
  logic [REG_AW-1:0] out_rd;
  logic              illegal;

  modport master (
    output in_valid, in_instr, flush, rf_rdata_a, rf_rdata_b,
           wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, rf_raddr_a, rf_raddr_b, out_valid, out_op,
           out_a, out_sh_amt, out_rd, illegal
  );

  modport slave (
    input  in_valid, in_instr, flush, rf_rdata_a, rf_rdata_b,
           wb_en, wb_addr, wb_data, out_ready,
    output in_ready, rf_raddr_a, rf_raddr_b, out_valid, out_op,
           out_a, out_sh_amt, out_rd, illegal
  );
endinterface

// File: rtl/shift_skid_buffer.sv
// Generic 2-entry valid/ready buffer: an output register backed by a skid
// register. in_ready depends only on registered state.
module shift_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         out_vld_q;
  logic         skid_vld_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         push;
  logic         pop;

  assign in_ready  = !skid_vld_q;
  assign push      = in_valid && !skid_vld_q;
  assign pop       = out_vld_q && out_ready;
  assign out_valid = out_vld_q;
  assign out_data  = out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (!out_vld_q || pop) begin
      // Output slot frees up: the older skid entry always goes first.
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= push;
        if (push) skid_q <= in_data;
      end else begin
        out_vld_q <= push;
        if (push) out_q <= in_data;
      end
    end else if (push) begin
      skid_vld_q <= 1'b1;
      skid_q     <= in_data;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Operand-fetch/issue stage ahead of the shifter: decodes shift words, reads and
// bypasses operands, and queues {op, a, sh_amt, rd} in a 2-entry buffer.
module shift_issue_stage #(
  parameter int         DATA_W       = 32,
  parameter int         REG_AW       = 5,
  parameter logic [5:0] SHIFT_OPCODE = shift_issue_stage_pkg::SHIFT_OPCODE
) (
  input logic             clk,
  input logic             rst_n,
  shift_issue_stage_if.slave bus
);
  import shift_issue_stage_pkg::*;

  localparam int SH_W  = 5;
  localparam int PAY_W = 3 + DATA_W + SH_W + REG_AW;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [SH_W-1:0]   shamt;
  logic [3:0]        funct;

  assign opcode = bus.in_instr[OPC_MSB:OPC_LSB];
  assign rs     = bus.in_instr[RS_MSB:RS_LSB];
  assign rt     = bus.in_instr[RT_MSB:RT_LSB];
  assign shamt  = bus.in_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = bus.in_instr[FUNCT_MSB:FUNCT_LSB];

  assign bus.rf_raddr_a = rs;
  assign bus.rf_raddr_b = rt;

  // Same-cycle writeback wins over the register-file read; r0 is ordinary.
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  assign opnd_a = (bus.wb_en && bus.wb_addr == rs) ? bus.wb_data : bus.rf_rdata_a;
  assign opnd_b = (bus.wb_en && bus.wb_addr == rt) ? bus.wb_data : bus.rf_rdata_b;

  funct_dec_t      dec;
  logic            legal;
  logic [SH_W-1:0] amount;
  assign dec    = decode_funct(funct);
  assign legal  = (opcode == SHIFT_OPCODE) && dec.legal;
  assign amount = dec.use_rt ? opnd_b[SH_W-1:0] : shamt;

  logic accept;
  logic push;
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal && !bus.flush;

  logic [PAY_W-1:0] in_payload;
  logic [PAY_W-1:0] out_payload;
  assign in_payload = {dec.op, opnd_a, amount, rs};

  shift_skid_buffer #(.W(PAY_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (push),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign {bus.out_op, bus.out_a, bus.out_sh_amt, bus.out_rd} = out_payload;

  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= accept && !legal && !bus.flush;
  end
  assign bus.illegal = illegal_q;

  // Instruction bits [10:4] and the upper rt-value bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.in_instr[10:4], opnd_b[DATA_W-1:SH_W]};

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations for key scenarios.
module tb_shift_issue_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_issue_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  shift_issue_stage #(
    .DATA_W       (32),
    .REG_AW       (5),
    .SHIFT_OPCODE (6'b000001)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] rf [32];
  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

  int n_checks = 0;
  int n_pass   = 0;

  logic [44:0] exp_q[$];
  logic        exp_illegal = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] enc(input logic [5:0] opc, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] sh,
                                      input logic [3:0] fn);
    return {opc, rs, rt, sh, 7'b0, fn};
  endfunction

  // Reference rules: which words are legal shifts and what entry they produce.
  function automatic logic model_decode(input logic [31:0] w, input logic wen,
                                        input logic [4:0] waddr, input logic [31:0] wdata,
                                        output logic [44:0] e);
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] va;
    logic [31:0] vb;
    logic [2:0]  op;
    logic [4:0]  amt;
    logic        ok;
    rs = w[25:21];
    rt = w[20:16];
    va = (wen && waddr == rs) ? wdata : rf[rs];
    vb = (wen && waddr == rt) ? wdata : rf[rt];
    ok = (w[31:26] == 6'b000001);
    case (w[3:0])
      4'd0:    begin op = 3'b011; amt = w[15:11]; end
      4'd1:    begin op = 3'b100; amt = w[15:11]; end
      4'd2:    begin op = 3'b101; amt = w[15:11]; end
      4'd4:    begin op = 3'b011; amt = vb[4:0];  end
      4'd5:    begin op = 3'b100; amt = vb[4:0];  end
      4'd6:    begin op = 3'b101; amt = vb[4:0];  end
      default: begin op = 3'b000; amt = 5'd0; ok = 1'b0; end
    endcase
    e = {op, va, amt, rs};
    return ok;
  endfunction

  always @(posedge clk) begin
    logic        acc;
    logic        cons;
    logic        ok;
    logic [44:0] e;
    if (!rst_n) begin
      exp_q.delete();
      exp_illegal = 1'b0;
    end else begin
      acc  = bus.in_valid && (exp_q.size() < 2);
      cons = (exp_q.size() > 0) && bus.out_ready;
      ok   = model_decode(bus.in_instr, bus.wb_en, bus.wb_addr, bus.wb_data, e);
      if (bus.flush) begin
        exp_q.delete();
        exp_illegal = 1'b0;
      end else begin
        if (cons) void'(exp_q.pop_front());
        if (acc && ok) exp_q.push_back(e);
        exp_illegal = acc && !ok;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready", bus.in_ready, exp_q.size() < 2);
      check("model_out_valid", bus.out_valid, exp_q.size() > 0);
      check("model_illegal", bus.illegal, exp_illegal);
      if (exp_q.size() > 0)
        check("model_entry", {bus.out_op, bus.out_a, bus.out_sh_amt, bus.out_rd}, exp_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    bus.in_valid = v;
    bus.in_instr = w;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | i;
    rf[3] = 32'h0000_00F1;
    rf[4] = 32'hFFFF_FFE5;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;

    rst_n = 1'b0;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_op", bus.out_op, 3'b000);
    check("rst_out_a", bus.out_a, 32'h0);
    check("rst_out_sh_amt", bus.out_sh_amt, 5'd0);
    check("rst_out_rd", bus.out_rd, 5'd0);
    check("rst_illegal", bus.illegal, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;

    // shll r3,7
    drive(1'b1, enc(6'b000001, 5'd3, 5'd0, 5'd7, 4'd0));
    tick();
    drive(1'b0, '0);
    check("shll_valid", bus.out_valid, 1'b1);
    check("shll_op", bus.out_op, 3'b011);
    check("shll_a", bus.out_a, 32'h0000_00F1);
    check("shll_amt", bus.out_sh_amt, 5'd7);
    check("shll_rd", bus.out_rd, 5'd3);
    tick();

    // shrav r2,r4 with writeback to r2 in the same cycle
    bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h8000_0000;
    drive(1'b1, enc(6'b000001, 5'd2, 5'd4, 5'd0, 4'd6));
    tick();
    bus.wb_en = 1'b0;
    drive(1'b0, '0);
    check("shrav_a", bus.out_a, 32'h8000_0000);
    check("shrav_amt", bus.out_sh_amt, 5'd5);
    check("shrav_op", bus.out_op, 3'b101);
    tick();

    // shllv r5,r6 with rt bypassed; only the low 5 bits of rt matter
    bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h0000_0133;
    drive(1'b1, enc(6'b000001, 5'd5, 5'd6, 5'd0, 4'd4));
    tick();
    check("shllv_a", bus.out_a, 32'hA000_0005);
    check("shllv_amt", bus.out_sh_amt, 5'd19);
    // shrl r0,31 with r0 bypassed like any other register
    bus.wb_addr = 5'd0; bus.wb_data = 32'h1234_5678;
    drive(1'b1, enc(6'b000001, 5'd0, 5'd9, 5'd31, 4'd1));
    tick();
    bus.wb_en = 1'b0;
    drive(1'b0, '0);
    check("shrl_r0_a", bus.out_a, 32'h1234_5678);
    check("shrl_r0_op", bus.out_op, 3'b100);
    check("shrl_r0_amt", bus.out_sh_amt, 5'd31);
    tick();

    // Backpressure: three back-to-back words with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, enc(6'b000001, 5'd1, 5'd0, 5'd1, 4'd0));
    tick();
    drive(1'b1, enc(6'b000001, 5'd2, 5'd0, 5'd2, 4'd1));
    tick();
    check("bp_full_in_ready", bus.in_ready, 1'b0);
    drive(1'b1, enc(6'b000001, 5'd7, 5'd0, 5'd3, 4'd2));
    tick();
    check("bp_hold_rd", bus.out_rd, 5'd1);
    check("bp_hold_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_second_rd", bus.out_rd, 5'd2);
    check("bp_reopen_in_ready", bus.in_ready, 1'b1);
    tick();
    drive(1'b0, '0);
    check("bp_third_rd", bus.out_rd, 5'd7);
    check("bp_third_op", bus.out_op, 3'b101);
    tick();
    check("bp_drained", bus.out_valid, 1'b0);

    // Illegal opcode and illegal funct
    drive(1'b1, enc(6'b000010, 5'd1, 5'd1, 5'd1, 4'd0));
    tick();
    drive(1'b0, '0);
    check("ill_opc_pulse", bus.illegal, 1'b1);
    check("ill_opc_no_out", bus.out_valid, 1'b0);
    tick();
    check("ill_opc_end", bus.illegal, 1'b0);
    drive(1'b1, enc(6'b000001, 5'd1, 5'd1, 5'd1, 4'd3));
    tick();
    drive(1'b0, '0);
    check("ill_fn_pulse", bus.illegal, 1'b1);
    check("ill_fn_no_out", bus.out_valid, 1'b0);
    tick();

    // Flush with two entries buffered and a word incoming
    bus.out_ready = 1'b0;
    drive(1'b1, enc(6'b000001, 5'd8, 5'd0, 5'd4, 4'd0));
    tick();
    drive(1'b1, enc(6'b000001, 5'd9, 5'd0, 5'd5, 4'd1));
    tick();
    drive(1'b1, enc(6'b000001, 5'd10, 5'd0, 5'd6, 4'd2));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, '0);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_nothing_after", bus.out_valid, 1'b0);
    end
    drive(1'b1, enc(6'b000011, 5'd1, 5'd1, 5'd1, 4'd0));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, '0);
    check("flush_ill_suppressed", bus.illegal, 1'b0);
    tick();

    // Reset while both entries are full
    bus.out_ready = 1'b0;
    drive(1'b1, enc(6'b000001, 5'd11, 5'd0, 5'd9, 4'd2));
    tick();
    drive(1'b1, enc(6'b000001, 5'd12, 5'd0, 5'd10, 4'd1));
    tick();
    drive(1'b0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_out_valid", bus.out_valid, 1'b0);
    check("rst2_outs_zero", {bus.out_op, bus.out_a, bus.out_sh_amt, bus.out_rd, bus.illegal}, '0);
    check("rst2_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;

    // Mixed stream over every funct value with bursty out_ready and bypass
    for (int i = 0; i < 24; i++) begin
      bus.out_ready = (i % 3) != 0;
      bus.wb_en     = (i % 2) == 1;
      bus.wb_addr   = 5'(i + 1);
      bus.wb_data   = 32'hC0DE_0000 + 32'(i * 37);
      drive(1'b1, enc((i == 13) ? 6'b100001 : 6'b000001, 5'(i + 1), 5'(i + 2),
                      5'(i * 3), 4'(i % 8)));
      tick();
    end
    drive(1'b0, '0);
    bus.wb_en     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("end_drained", bus.out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
